div_share_ctrl: RTL and testbench

Controller that shares one sequential 16/8 divider among `NREQ` requesters. Each requester offers a dividend/divisor pair on a valid/ready handshake. The block grants requesters round-robin, loads the operands into the divider, pulses its start, and waits for done. It then returns quotient and remainder, tagged with the requester ID, on a single back-pressured response channel.

---
 rtl/div_ctrl_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/div_share_ctrl.sv | 140 ++++++++++++++
 tb/tb_div_share_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the shared-divider controller.
package div_ctrl_pkg;
  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam logic [7:0] DBZ_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr_i, with wrap.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o
);

  int j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    j       = 0;
    // Scan from farthest to nearest so the nearest requester wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (req_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one sequential 16/8 divider among NREQ requesters, round-robin.
// Optional DIV_ZERO_CHECK_EN: zero divisors are answered locally without the divider.
// States: IDLE grant/capture | ISSUE start pulse | WAIT await done | RESP hold response
module div_share_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [16*NREQ-1:0]     req_dividend,
  input  logic [8*NREQ-1:0]      req_divisor,
  output logic                   div_start,
  output logic [DIVIDEND_W-1:0]  div_dividend,
  output logic [DIVISOR_W-1:0]   div_divisor,
  input  logic                   div_done,
  input  logic [7:0]             div_quotient,
  input  logic [7:0]             div_rem,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [7:0]             resp_quotient,
  output logic [7:0]             resp_rem,
  output logic                   resp_dbz
);

  state_t                  state_q;
  logic [IDW-1:0]          ptr_q;
  logic [IDW-1:0]          ptr_d;
  logic [IDW-1:0]          id_q;
  logic                    wait_first_q;
  logic                    div_start_q;
  logic [DIVIDEND_W-1:0]   div_dividend_q;
  logic [DIVISOR_W-1:0]    div_divisor_q;
  logic                    resp_valid_q;
  logic [IDW-1:0]          resp_id_q;
  logic [7:0]              resp_quotient_q;
  logic [7:0]              resp_rem_q;
  logic                    resp_dbz_q;

  logic [NREQ-1:0]         grant;
  logic [IDW-1:0]          gidx;
  logic [DIVIDEND_W-1:0]   grant_dividend;
  logic [DIVISOR_W-1:0]    grant_divisor;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (gidx)
  );

  assign grant_dividend = req_dividend[gidx*DIVIDEND_W +: DIVIDEND_W];
  assign grant_divisor  = req_divisor[gidx*DIVISOR_W +: DIVISOR_W];
  assign ptr_d          = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);

  assign req_ready = (state_q == IDLE && !rst) ? grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      id_q            <= '0;
      wait_first_q    <= 1'b0;
      div_start_q     <= 1'b0;
      div_dividend_q  <= '0;
      div_divisor_q   <= '0;
      resp_valid_q    <= 1'b0;
      resp_id_q       <= '0;
      resp_quotient_q <= '0;
      resp_rem_q      <= '0;
      resp_dbz_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            div_dividend_q <= grant_dividend;
            div_divisor_q  <= grant_divisor;
            id_q           <= gidx;
            ptr_q          <= ptr_d;
`ifdef DIV_ZERO_CHECK_EN
            if (grant_divisor == '0) begin
              state_q         <= RESP;
              resp_valid_q    <= 1'b1;
              resp_id_q       <= gidx;
              resp_quotient_q <= DBZ_QUOTIENT;
              resp_rem_q      <= grant_dividend[7:0];
              resp_dbz_q      <= 1'b1;
            end else
`endif
            begin
              state_q     <= ISSUE;
              div_start_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          div_start_q  <= 1'b0;
          wait_first_q <= 1'b1;
          state_q      <= WAIT;
        end
        WAIT: begin
          // First WAIT cycle may still see the previous operation's done level.
          wait_first_q <= 1'b0;
          if (!wait_first_q && div_done) begin
            resp_valid_q    <= 1'b1;
            resp_id_q       <= id_q;
            resp_quotient_q <= div_quotient;
            resp_rem_q      <= div_rem;
            resp_dbz_q      <= 1'b0;
            state_q         <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div_start     = div_start_q;
  assign div_dividend  = div_dividend_q;
  assign div_divisor   = div_divisor_q;
  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_quotient = resp_quotient_q;
  assign resp_rem      = resp_rem_q;
  assign resp_dbz      = resp_dbz_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with a behavioural divider whose done level lingers one cycle.
module tb_div_share_ctrl;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int DLAT = 3;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [16*NREQ-1:0] req_dividend;
  logic [8*NREQ-1:0] req_divisor;
  logic              div_start;
  logic [15:0]       div_dividend;
  logic [7:0]        div_divisor;
  logic              div_done;
  logic [7:0]        div_quotient;
  logic [7:0]        div_rem;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [7:0]        resp_quotient;
  logic [7:0]        resp_rem;
  logic              resp_dbz;

  logic [15:0] dd_a [NREQ];
  logic [7:0]  dv_a [NREQ];
  logic [7:0]  eq_a [NREQ];
  logic [7:0]  er_a [NREQ];

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int width_err = 0;
  logic prev_start = 1'b0;

  div_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_rem       (div_rem),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_quotient (resp_quotient),
    .resp_rem      (resp_rem),
    .resp_dbz      (resp_dbz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    req_dividend = {dd_a[3], dd_a[2], dd_a[1], dd_a[0]};
    req_divisor  = {dv_a[3], dv_a[2], dv_a[1], dv_a[0]};
  end

  // Divider model: done keeps its old level for the first cycle after start, results update with done.
  int          m_cnt = 0;
  logic [15:0] m_dd = '0;
  logic [7:0]  m_dv = '0;
  initial begin
    div_done = 1'b0;
    div_quotient = '0;
    div_rem = '0;
  end
  always @(posedge clk) begin
    if (div_start) begin
      m_cnt <= 1;
      m_dd  <= div_dividend;
      m_dv  <= div_divisor;
    end else if (m_cnt != 0) begin
      if (m_cnt + 1 >= DLAT) begin
        div_done <= 1'b1;
        m_cnt    <= 0;
        if (m_dv == 8'd0) begin
          div_quotient <= 8'hFF;
          div_rem      <= m_dd[7:0];
        end else begin
          div_quotient <= 8'(m_dd / {8'd0, m_dv});
          div_rem      <= 8'(m_dd % {8'd0, m_dv});
        end
      end else begin
        div_done <= 1'b0;
        m_cnt    <= m_cnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (div_start) start_cnt <= start_cnt + 1;
    if (div_start && prev_start) width_err <= width_err + 1;
    prev_start <= div_start;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge after the response handshake.
  task automatic serve(input logic [NREQ-1:0] vmask, input int eid, input int hold, input string tag);
    logic edbz;
    int lat;
    int s0;
    int bad;
    logic [IDW-1:0] sid;
    logic [7:0] sq, sr;
`ifdef DIV_ZERO_CHECK_EN
    edbz = (dv_a[eid] == 8'd0);
`else
    edbz = 1'b0;
`endif
    req_valid = vmask;
    #1;
    chk({tag, ".grant"}, req_ready, 64'(1 << eid));
    s0 = start_cnt;
    @(negedge clk);
    req_valid[eid] = 1'b0;
    chk({tag, ".start"}, div_start, edbz ? 64'd0 : 64'd1);
    if (!edbz)
      chk({tag, ".operands"}, {div_dividend, div_divisor}, {dd_a[eid], dv_a[eid]});
    lat = 1;
    while (!resp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, lat, edbz ? 64'd1 : 64'(DLAT + 2));
    chk({tag, ".resp"}, {resp_id, resp_quotient, resp_rem, resp_dbz},
        {IDW'(eid), eq_a[eid], er_a[eid], edbz});
    chk({tag, ".ready_in_resp"}, req_ready, 64'd0);
    if (hold > 0) begin
      bad = 0;
      sid = resp_id;
      sq = resp_quotient;
      sr = resp_rem;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!resp_valid || resp_id != sid || resp_quotient != sq || resp_rem != sr ||
            req_ready != '0 || div_start)
          bad++;
      end
      chk({tag, ".hold_stable"}, bad, 64'd0);
    end
    chk({tag, ".start_count"}, start_cnt - s0, edbz ? 64'd0 : 64'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, ".resp_cleared"}, resp_valid, 64'd0);
  endtask

  typedef struct {
    int          id;
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [7:0]  q;
    logic [7:0]  r;
  } vec_t;

  vec_t vt [7];
  int   seen;

  initial begin
    vt[0] = '{1, 16'd1000, 8'd10, 8'd100, 8'd0};
    vt[1] = '{3, 16'd500, 8'd7, 8'd71, 8'd3};
    vt[2] = '{0, 16'd255, 8'd16, 8'd15, 8'd15};
    vt[3] = '{2, 16'd100, 8'd100, 8'd1, 8'd0};
    vt[4] = '{0, 16'd5, 8'd9, 8'd0, 8'd5};
    vt[5] = '{1, 16'd2550, 8'd255, 8'd10, 8'd0};
    vt[6] = '{2, 16'h1234, 8'd0, 8'hFF, 8'h34};

    dd_a[0] = 16'd200;  dv_a[0] = 8'd7;  eq_a[0] = 8'd28;  er_a[0] = 8'd4;
    dd_a[1] = 16'd1000; dv_a[1] = 8'd10; eq_a[1] = 8'd100; er_a[1] = 8'd0;
    dd_a[2] = 16'd65;   dv_a[2] = 8'd9;  eq_a[2] = 8'd7;   er_a[2] = 8'd2;
    dd_a[3] = 16'd500;  dv_a[3] = 8'd7;  eq_a[3] = 8'd71;  er_a[3] = 8'd3;

    rst = 1'b1;
    req_valid = '1;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {req_ready, div_start, div_dividend, div_divisor, resp_valid,
                          resp_id, resp_quotient, resp_rem, resp_dbz}, 64'd0);
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_grant", req_ready, 64'd0);

    serve(4'b0101, 0, 0, "pair_first");
    serve(4'b0100, 2, 0, "pair_second");
    serve(4'b1010, 3, 0, "ptr_from_3");

    for (int k = 0; k < 5; k++) serve(4'b1111, k % 4, 0, "round_robin");

    serve(4'b1010, 1, 5, "backpressure");

    for (int i = 0; i < 7; i++) begin
      dd_a[vt[i].id] = vt[i].dd;
      dv_a[vt[i].id] = vt[i].dv;
      eq_a[vt[i].id] = vt[i].q;
      er_a[vt[i].id] = vt[i].r;
      serve(4'(1 << vt[i].id), vt[i].id, 0, "vector");
    end

    // Abandon an operation with reset in its second WAIT cycle.
    dd_a[1] = 16'd1000; dv_a[1] = 8'd10;
    req_valid = 4'b0010;
    #1;
    chk("rst_wait.grant", req_ready, 64'b0010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait.outputs", {req_ready, div_start, div_dividend, div_divisor, resp_valid,
                             resp_id, resp_quotient, resp_rem, resp_dbz}, 64'd0);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("rst_wait.no_response", seen, 64'd0);
    dd_a[2] = 16'd65; dv_a[2] = 8'd9; eq_a[2] = 8'd7; er_a[2] = 8'd2;
    serve(4'b0100, 2, 0, "after_reset");

    chk("start_width", width_err, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
